aesl_axis_deadlock_detector: RTL and testbench
==============================================

// Module: aesl_axis_deadlock_detector
// PURPOSE
// Parametrised co-simulation deadlock detector for one dataflow region of the yolo top.
// Flags a deadlock only when every sub-instance is idle or stalled, not all are idle,
// and at least one AXIS channel is stalled, all continuously for THRESH cycles.
// On detection it latches a per-channel snapshot (empty/full stall cause) and holds it
// until cleared. It is the counterpart of the fixed-width per-level monitors,
// generalised to N channels and M instances.
// PARAMETERS
// NUM_AXIS  2   number of monitored AXIS channels (>=1)
// NUM_INST  2   number of monitored sub-instances (>=1)
// THRESH    1   consecutive suspect cycles required before declaring deadlock (>=1)
// CNT_W     16  width of the suspect counter and the deadlock event counter
// PORTS
// clock            in   1           single clock, all logic on rising edge
// reset            in   1           synchronous, active-high
// enable           in   1           1 = monitoring active; 0 = hold in WATCH
// clear            in   1           1 = drop a latched deadlock, return to WATCH
// axis_empty_sigs  in   NUM_AXIS    ch k consumer stalled on empty stream
// axis_full_sigs   in   NUM_AXIS    ch k producer stalled on full stream
// inst_idle_sigs   in   NUM_INST    instance j idle
// inst_block_sigs  in   NUM_INST    instance j stalled on a channel
// block            out  1           deadlock latched
// axis_block_info  out  2*NUM_AXIS  bits[2k+1:2k] = {full[k],empty[k]} snapshot; 0 unless block
// suspect_cnt      out  CNT_W       current consecutive suspect-cycle count
// deadlock_events  out  CNT_W       number of WATCH/SUSPECT->DEADLOCK entries, saturating
// BEHAVIOUR
// - Reset: state=WATCH; block=0, axis_block_info=0, suspect_cnt=0, deadlock_events=0.
// - cond = enable & |(axis_empty_sigs|axis_full_sigs) & &(inst_idle_sigs|inst_block_sigs)
//   & ~&inst_idle_sigs  (all-idle = normal completion, never a deadlock).
// - States: WATCH (cnt=0), SUSPECT (counting), DEADLOCK (latched).
// - WATCH: cond & THRESH==1 -> DEADLOCK; cond & THRESH>1 -> SUSPECT, cnt<=1; else stay.
// - SUSPECT: ~cond -> WATCH, cnt<=0; cond & cnt==THRESH-1 -> DEADLOCK; else cnt<=cnt+1.
// - Latency: cond high on cycles t..t+THRESH-1 -> block=1 from cycle t+THRESH (registered).
// - Entry to DEADLOCK: latch info from the same-cycle axis sigs; cnt<=0;
//   deadlock_events +=1, saturating at all-ones.
// - DEADLOCK: block=1, info frozen regardless of inputs/enable; exits only on clear or reset.
// - clear in DEADLOCK -> WATCH next cycle, block=0, info=0; that cycle's cond not counted.
// - clear in WATCH/SUSPECT: forces WATCH, cnt<=0 (clear beats cond).
// - enable=0: cond=0, so SUSPECT falls to WATCH; DEADLOCK unaffected.
// - cnt never exceeds THRESH-1; CNT_W must satisfy 2^CNT_W > THRESH (elaboration check).
// - Reset mid-SUSPECT/DEADLOCK: all state and counters return to reset values next edge.
// - X on inputs while reset=1 must not propagate to outputs.
// TESTING
// 1 THRESH=1, inst_idle=01, inst_block=10, axis_empty=01 for 1 cycle -> block=1 next cycle,
//   axis_block_info=4'b0001, deadlock_events=1.
// 2 THRESH=4, cond high 3 cycles then low -> block never 1, suspect_cnt 1,2,3,0;
//   cond high 4 cycles -> block=1 on 5th edge.
// 3 inst_idle=11 with axis_full=11 -> no detection (normal done); block stays 0 for 100 cycles.
// 4 In DEADLOCK, change axis sigs to 00 -> info unchanged; pulse clear with cond=1 ->
//   block=0 next cycle, suspect_cnt=0, then re-detect after THRESH further cond cycles.
// 5 NUM_AXIS=4, axis_full=1000, axis_empty=0010 -> info=8'b10_00_01_00; CNT_W=2, 4 detect/clear
//   cycles -> deadlock_events saturates at 3.
// 6 Assert reset in SUSPECT (cnt=2) and in DEADLOCK -> all outputs 0 next cycle.

Source files
------------

// File: rtl/aesl_axis_deadlock_detector.sv
// rtl/aesl_axis_deadlock_detector.sv - dataflow-region deadlock detector over N AXIS channels and M instances
// Latches a per-channel {full,empty} stall snapshot once the suspect condition persists THRESH cycles.
module aesl_axis_deadlock_detector #(
    parameter int NUM_AXIS = 2,
    parameter int NUM_INST = 2,
    parameter int THRESH   = 1,
    parameter int CNT_W    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [NUM_AXIS-1:0]   axis_empty_sigs,
    input  logic [NUM_AXIS-1:0]   axis_full_sigs,
    input  logic [NUM_INST-1:0]   inst_idle_sigs,
    input  logic [NUM_INST-1:0]   inst_block_sigs,
    output logic                  block,
    output logic [2*NUM_AXIS-1:0] axis_block_info,
    output logic [CNT_W-1:0]      suspect_cnt,
    output logic [CNT_W-1:0]      deadlock_events
);

    // The suspect counter must be able to hold THRESH-1 and the parameters must be positive.
    if (NUM_AXIS < 1 || NUM_INST < 1 || THRESH < 1 || CNT_W < 1 || (THRESH >> CNT_W) != 0) begin : g_param_check
        $error("aesl_axis_deadlock_detector: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(THRESH - 1);
    localparam logic [CNT_W-1:0] EV_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        WATCH    = 2'd0,
        SUSPECT  = 2'd1,
        DEADLOCK = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      events_q, events_d;
    logic [2*NUM_AXIS-1:0] info_q, info_d;
    logic [2*NUM_AXIS-1:0] snap;
    logic                  cond;
    logic                  enter_dl;

    always_comb begin
        // All-idle is normal completion, so at least one instance must be genuinely blocked.
        cond = enable
             & (|(axis_empty_sigs | axis_full_sigs))
             & (&(inst_idle_sigs | inst_block_sigs))
             & ~(&inst_idle_sigs);

        snap = '0;
        for (int k = 0; k < NUM_AXIS; k++) begin
            snap[2*k]   = axis_empty_sigs[k];
            snap[2*k+1] = axis_full_sigs[k];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        info_d   = info_q;
        events_d = events_q;
        enter_dl = 1'b0;

        case (state_q)
            WATCH: begin
                cnt_d = '0;
                if (!clear && cond) begin
                    if (THRESH == 1) begin
                        enter_dl = 1'b1;
                    end else begin
                        state_d = SUSPECT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            SUSPECT: begin
                if (clear || !cond) begin
                    state_d = WATCH;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_CNT) begin
                    enter_dl = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DEADLOCK: begin
                // Snapshot stays frozen until an explicit clear.
                if (clear) begin
                    state_d = WATCH;
                    cnt_d   = '0;
                    info_d  = '0;
                end
            end
            default: begin
                state_d = WATCH;
                cnt_d   = '0;
                info_d  = '0;
            end
        endcase

        if (enter_dl) begin
            state_d  = DEADLOCK;
            cnt_d    = '0;
            info_d   = snap;
            events_d = (events_q == EV_MAX) ? events_q : events_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= WATCH;
            cnt_q    <= '0;
            info_q   <= '0;
            events_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            info_q   <= info_d;
            events_q <= events_d;
        end
    end

    assign block           = (state_q == DEADLOCK);
    assign axis_block_info = info_q;
    assign suspect_cnt     = cnt_q;
    assign deadlock_events = events_q;

endmodule

// File: tb/tb_aesl_axis_deadlock_detector.sv
// tb/tb_aesl_axis_deadlock_detector.sv - bench for aesl_axis_deadlock_detector
// Three instances (THRESH 1/4/2, one with 4 channels and 2-bit counters) share one stimulus bus.
module tb_aesl_axis_deadlock_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, clr;
    logic [3:0] emp, ful;
    logic [2:0] idl, blk;

    logic        d1_block, d4_block, dw_block;
    logic [3:0]  d1_info, d4_info;
    logic [7:0]  dw_info;
    logic [15:0] d1_cnt, d1_ev, d4_cnt, d4_ev;
    logic [1:0]  dw_cnt, dw_ev;

    aesl_axis_deadlock_detector #(.NUM_AXIS(2), .NUM_INST(2), .THRESH(1), .CNT_W(16)) d1 (
        .clock(clk), .reset(rst), .enable(en), .clear(clr),
        .axis_empty_sigs(emp[1:0]), .axis_full_sigs(ful[1:0]),
        .inst_idle_sigs(idl[1:0]), .inst_block_sigs(blk[1:0]),
        .block(d1_block), .axis_block_info(d1_info), .suspect_cnt(d1_cnt), .deadlock_events(d1_ev));

    aesl_axis_deadlock_detector #(.NUM_AXIS(2), .NUM_INST(2), .THRESH(4), .CNT_W(16)) d4 (
        .clock(clk), .reset(rst), .enable(en), .clear(clr),
        .axis_empty_sigs(emp[1:0]), .axis_full_sigs(ful[1:0]),
        .inst_idle_sigs(idl[1:0]), .inst_block_sigs(blk[1:0]),
        .block(d4_block), .axis_block_info(d4_info), .suspect_cnt(d4_cnt), .deadlock_events(d4_ev));

    aesl_axis_deadlock_detector #(.NUM_AXIS(4), .NUM_INST(3), .THRESH(2), .CNT_W(2)) dw (
        .clock(clk), .reset(rst), .enable(en), .clear(clr),
        .axis_empty_sigs(emp), .axis_full_sigs(ful),
        .inst_idle_sigs(idl), .inst_block_sigs(blk),
        .block(dw_block), .axis_block_info(dw_info), .suspect_cnt(dw_cnt), .deadlock_events(dw_ev));

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a run length of consecutive qualifying cycles and a latched flag per instance.
    int         th[3]    = '{1, 4, 2};
    int         evmax[3] = '{65535, 65535, 3};
    int         na[3]    = '{2, 2, 4};
    int         ni[3]    = '{2, 2, 3};
    bit         lat[3];
    int         streak[3];
    logic [7:0] minfo[3];
    int         mev[3];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            int  am, im;
            bit  c;
            logic [7:0] s;
            am = (1 << na[i]) - 1;
            im = (1 << ni[i]) - 1;
            if (rst) begin
                lat[i] = 0; streak[i] = 0; minfo[i] = '0; mev[i] = 0;
            end else begin
                c = en && ((int'(emp | ful) & am) != 0) && ((int'(idl | blk) & im) == im)
                    && ((int'(idl) & im) != im);
                s = '0;
                for (int k = 0; k < na[i]; k++) begin
                    s[2*k]   = emp[k];
                    s[2*k+1] = ful[k];
                end
                if (lat[i]) begin
                    if (clr) begin lat[i] = 0; minfo[i] = '0; end
                end else if (clr || !c) begin
                    streak[i] = 0;
                end else begin
                    streak[i]++;
                    if (streak[i] >= th[i]) begin
                        lat[i] = 1; streak[i] = 0; minfo[i] = s;
                        if (mev[i] < evmax[i]) mev[i]++;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("d1_block", d1_block, lat[0]);
        check("d1_info",  d1_info,  minfo[0]);
        check("d1_cnt",   d1_cnt,   streak[0]);
        check("d1_ev",    d1_ev,    mev[0]);
        check("d4_block", d4_block, lat[1]);
        check("d4_info",  d4_info,  minfo[1]);
        check("d4_cnt",   d4_cnt,   streak[1]);
        check("d4_ev",    d4_ev,    mev[1]);
        check("dw_block", dw_block, lat[2]);
        check("dw_info",  dw_info,  minfo[2]);
        check("dw_cnt",   dw_cnt,   streak[2]);
        check("dw_ev",    dw_ev,    mev[2]);
    endtask

    task automatic set_cond(input logic [3:0] e, input logic [3:0] f);
        en = 1'b1; clr = 1'b0; rst = 1'b0;
        emp = e; ful = f; idl = 3'b001; blk = 3'b110;
    endtask

    typedef struct {
        logic       rst, en, clr;
        logic [1:0] emp, ful, idl, blk;
        logic       e_b1;
        logic [3:0] e_i1;
        int         e_c4;
        logic       e_b4;
    } vec_t;

    vec_t tbl[11];
    bit   any_b;

    initial begin
        tbl[0]  = '{1'b1, 1'bx, 1'bx, 2'bxx, 2'bxx, 2'bxx, 2'bxx, 1'b0, 4'b0000, 0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 2'b10, 1'b0, 4'b0000, 0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 2'b10, 1'b1, 4'b0001, 1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 2'b10, 1'b1, 4'b0001, 2, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 2'b10, 1'b1, 4'b0001, 3, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 2'b10, 1'b1, 4'b0001, 0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b01, 2'b10, 1'b0, 4'b0000, 0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 2'b10, 1'b1, 4'b0001, 1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 2'b10, 1'b1, 4'b0001, 2, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 2'b10, 1'b1, 4'b0001, 3, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 2'b10, 1'b1, 4'b0001, 0, 1'b1};

        rst = 1'b1; en = 1'b0; clr = 1'b0; emp = '0; ful = '0; idl = '0; blk = '0;

        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; clr = tbl[i].clr;
            emp = {2'b00, tbl[i].emp}; ful = {2'b00, tbl[i].ful};
            idl = {1'b0, tbl[i].idl};  blk = {1'b0, tbl[i].blk};
            step();
            check("tbl_d1_block", d1_block, tbl[i].e_b1);
            check("tbl_d1_info",  d1_info,  tbl[i].e_i1);
            check("tbl_d4_cnt",   d4_cnt,   tbl[i].e_c4);
            check("tbl_d4_block", d4_block, tbl[i].e_b4);
        end

        // All instances idle with full streams is normal completion.
        clr = 1'b1; step();
        clr = 1'b0; en = 1'b1; idl = 3'b111; blk = 3'b000; ful = 4'b1111; emp = 4'b0000;
        any_b = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            any_b |= d1_block | d4_block | dw_block;
        end
        check("t3_all_idle_noblock", any_b, 1'b0);

        // Frozen snapshot, clear beating cond, re-detection.
        set_cond(4'b0001, 4'b0000);
        repeat (4) step();
        check("t4_detect", d4_block, 1'b1);
        check("t4_info", d4_info, 4'b0001);
        emp = 4'b0000;
        repeat (3) step();
        check("t4_frozen_block", d4_block, 1'b1);
        check("t4_frozen_info", d4_info, 4'b0001);
        emp = 4'b0001; clr = 1'b1;
        step();
        check("t4_clear_block", d4_block, 1'b0);
        check("t4_clear_cnt", d4_cnt, 0);
        clr = 1'b0;
        repeat (3) step();
        check("t4_not_yet", d4_block, 1'b0);
        step();
        check("t4_redetect", d4_block, 1'b1);

        // Wide instance: interleaved snapshot and saturating 2-bit event counter.
        rst = 1'b1; step();
        set_cond(4'b0010, 4'b1000);
        for (int r = 0; r < 4; r++) begin
            repeat (2) step();
            check("t5_block", dw_block, 1'b1);
            check("t5_info", dw_info, 8'b10_00_01_00);
            check("t5_events", dw_ev, (r + 1 > 3) ? 3 : r + 1);
            clr = 1'b1; step(); clr = 1'b0;
        end

        // Reset in SUSPECT and in DEADLOCK.
        rst = 1'b1; step();
        set_cond(4'b0001, 4'b0000);
        repeat (2) step();
        check("t6_cnt2", d4_cnt, 2);
        rst = 1'b1; step();
        check("t6_rst_susp_cnt", d4_cnt, 0);
        check("t6_rst_susp_ev", d1_ev, 0);
        set_cond(4'b0001, 4'b0000);
        repeat (4) step();
        check("t6_dl", d4_block, 1'b1);
        rst = 1'b1; step();
        check("t6_rst_dl_block", d4_block, 1'b0);
        check("t6_rst_dl_info", d4_info, 4'b0000);
        check("t6_rst_dl_ev", d4_ev, 0);
        rst = 1'b0;

        // Randomized traffic biased toward the suspect condition.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            clr = ($urandom_range(0, 15) == 0);
            en  = ($urandom_range(0, 7) != 0);
            idl = 3'($urandom);
            blk = ($urandom_range(0, 3) == 0) ? 3'($urandom) : ~idl;
            emp = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            ful = 4'($urandom) & 4'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
